// File: rtl/regaccess_burst.sv
// SPI mode-0 slave bridge to a register file: 2-byte header, then DATA_W-bit words with optional auto-increment.
// Optional header status (0xA5 marker + previous word count) is built when REGACCESS_STATUS_EN is defined.
module regaccess_burst #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] regnum,
    input  logic [DATA_W-1:0] regdata_read,
    output logic [DATA_W-1:0] regdata_write,
    output logic              read,
    output logic              write
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR0 = 2'd1,
        ST_HDR1 = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_HDR_BIT  = 6'd7;
    localparam logic [CNT_W-1:0] LAST_WORD_BIT = CNT_W'(DATA_W - 1);

    state_t              state_r, state_nxt;
    logic                ss_meta_r, ss_sync_r;
    logic                sck_meta_r, sck_sync_r, sck_prev_r;
    logic                mosi_meta_r, mosi_sync_r;
    logic                armed_r;
    logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_nxt;
    logic [DATA_W-1:0]   rx_r, rx_nxt;
    logic [DATA_W-1:0]   tx_r, tx_nxt;
    logic [7:0]          hdr0_r, hdr0_nxt;
    logic                wr_r, wr_nxt;
    logic                inc_r, inc_nxt;
    logic                load_pend_r, load_pend_nxt;
    logic                miso_r, miso_nxt;
    logic [ADDR_W-1:0]   regnum_r, regnum_nxt;
    logic [DATA_W-1:0]   wdata_r, wdata_nxt;
    logic                read_r, read_nxt;
    logic                write_r, write_nxt;

    logic                sck_rise_s, sck_fall_s;
    logic [DATA_W-1:0]   rx_shift_s;
    logic [13:0]         addr_full_s;

`ifdef REGACCESS_STATUS_EN
    logic [7:0]          cur_cnt_r, cur_cnt_nxt;
    logic [7:0]          prev_cnt_r, prev_cnt_nxt;

    // Place a status byte at the MSB end of the transmit shifter.
    function automatic logic [DATA_W-1:0] top_byte(input logic [7:0] b);
        top_byte = DATA_W'(b) << (DATA_W - 8);
    endfunction
`endif

    assign sck_rise_s  = sck_sync_r & ~sck_prev_r;
    assign sck_fall_s  = ~sck_sync_r & sck_prev_r;
    assign rx_shift_s  = {rx_r[DATA_W-2:0], mosi_sync_r};
    assign addr_full_s = {hdr0_r[5:0], rx_shift_s[7:0]};

    // Input synchronisers; armed_r blocks a frame that was already selected when reset released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_meta_r   <= 1'b0;
            ss_sync_r   <= 1'b0;
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_prev_r  <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            ss_meta_r   <= ss;
            ss_sync_r   <= ss_meta_r;
            sck_meta_r  <= sck;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
            if (ss_sync_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_nxt     = state_r;
        bit_cnt_nxt   = bit_cnt_r;
        rx_nxt        = rx_r;
        tx_nxt        = tx_r;
        hdr0_nxt      = hdr0_r;
        wr_nxt        = wr_r;
        inc_nxt       = inc_r;
        load_pend_nxt = 1'b0;
        miso_nxt      = miso_r;
        regnum_nxt    = regnum_r;
        wdata_nxt     = wdata_r;
        read_nxt      = 1'b0;
        write_nxt     = 1'b0;
`ifdef REGACCESS_STATUS_EN
        cur_cnt_nxt   = cur_cnt_r;
        prev_cnt_nxt  = prev_cnt_r;
`endif

        if (write_r) begin
            regnum_nxt = regnum_r + ADDR_W'(inc_r);
        end else begin
            regnum_nxt = regnum_r;
        end

        // The MSB of each unit is preloaded, so the fall that opens a unit must not shift.
        if (sck_fall_s && (bit_cnt_r != {CNT_W{1'b0}})) begin
            tx_nxt   = {tx_r[DATA_W-2:0], 1'b0};
            miso_nxt = tx_r[DATA_W-2];
        end else begin
            tx_nxt   = tx_r;
        end

        case (state_r)
            ST_IDLE: begin
                bit_cnt_nxt = {CNT_W{1'b0}};
                rx_nxt      = {DATA_W{1'b0}};
                tx_nxt      = {DATA_W{1'b0}};
                miso_nxt    = 1'b0;
                if (armed_r && !ss_sync_r) begin
                    state_nxt    = ST_HDR0;
`ifdef REGACCESS_STATUS_EN
                    tx_nxt       = top_byte(8'hA5);
                    miso_nxt     = 1'b1;
                    prev_cnt_nxt = cur_cnt_r;
                    cur_cnt_nxt  = 8'h00;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HDR0: begin
                if (sck_rise_s) begin
                    rx_nxt = rx_shift_s;
                    if (bit_cnt_r == LAST_HDR_BIT) begin
                        bit_cnt_nxt = {CNT_W{1'b0}};
                        hdr0_nxt    = rx_shift_s[7:0];
                        state_nxt   = ST_HDR1;
`ifdef REGACCESS_STATUS_EN
                        tx_nxt      = top_byte(prev_cnt_r);
                        miso_nxt    = prev_cnt_r[7];
`else
                        tx_nxt      = {DATA_W{1'b0}};
                        miso_nxt    = 1'b0;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt_r + 6'd1;
                    end
                end else begin
                    state_nxt = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (sck_rise_s) begin
                    rx_nxt = rx_shift_s;
                    if (bit_cnt_r == LAST_HDR_BIT) begin
                        bit_cnt_nxt = {CNT_W{1'b0}};
                        state_nxt   = ST_DATA;
                        wr_nxt      = hdr0_r[7];
                        inc_nxt     = hdr0_r[6];
                        regnum_nxt  = ADDR_W'(addr_full_s);
                        read_nxt    = ~hdr0_r[7];
                        rx_nxt      = {DATA_W{1'b0}};
                        tx_nxt      = {DATA_W{1'b0}};
                        miso_nxt    = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt_r + 6'd1;
                    end
                end else begin
                    state_nxt = ST_HDR1;
                end
            end
            ST_DATA: begin
                load_pend_nxt = read_r;
                if (load_pend_r) begin
                    tx_nxt   = regdata_read;
                    miso_nxt = regdata_read[DATA_W-1];
                end else begin
                    load_pend_nxt = read_r;
                end
                if (sck_rise_s) begin
                    rx_nxt = rx_shift_s;
                    if (bit_cnt_r == LAST_WORD_BIT) begin
                        bit_cnt_nxt = {CNT_W{1'b0}};
`ifdef REGACCESS_STATUS_EN
                        if (cur_cnt_r != 8'hFF) begin
                            cur_cnt_nxt = cur_cnt_r + 8'd1;
                        end else begin
                            cur_cnt_nxt = cur_cnt_r;
                        end
`endif
                        if (wr_r) begin
                            write_nxt = 1'b1;
                            wdata_nxt = rx_shift_s;
                        end else begin
                            // Prefetch the next word so its MSB is ready before the next fall.
                            regnum_nxt = regnum_r + ADDR_W'(inc_r);
                            read_nxt   = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt_r + 6'd1;
                    end
                end else begin
                    state_nxt = ST_DATA;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (ss_sync_r) begin
            state_nxt     = ST_IDLE;
            bit_cnt_nxt   = {CNT_W{1'b0}};
            rx_nxt        = {DATA_W{1'b0}};
            tx_nxt        = {DATA_W{1'b0}};
            miso_nxt      = 1'b0;
            load_pend_nxt = 1'b0;
            read_nxt      = 1'b0;
            write_nxt     = 1'b0;
        end else begin
            state_nxt     = state_nxt;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            rx_r        <= {DATA_W{1'b0}};
            tx_r        <= {DATA_W{1'b0}};
            hdr0_r      <= 8'h00;
            wr_r        <= 1'b0;
            inc_r       <= 1'b0;
            load_pend_r <= 1'b0;
            miso_r      <= 1'b0;
            regnum_r    <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            read_r      <= 1'b0;
            write_r     <= 1'b0;
`ifdef REGACCESS_STATUS_EN
            cur_cnt_r   <= 8'h00;
            prev_cnt_r  <= 8'h00;
`endif
        end else begin
            state_r     <= state_nxt;
            bit_cnt_r   <= bit_cnt_nxt;
            rx_r        <= rx_nxt;
            tx_r        <= tx_nxt;
            hdr0_r      <= hdr0_nxt;
            wr_r        <= wr_nxt;
            inc_r       <= inc_nxt;
            load_pend_r <= load_pend_nxt;
            miso_r      <= miso_nxt;
            regnum_r    <= regnum_nxt;
            wdata_r     <= wdata_nxt;
            read_r      <= read_nxt;
            write_r     <= write_nxt;
`ifdef REGACCESS_STATUS_EN
            cur_cnt_r   <= cur_cnt_nxt;
            prev_cnt_r  <= prev_cnt_nxt;
`endif
        end
    end

    assign miso          = miso_r;
    assign regnum        = regnum_r;
    assign regdata_write = wdata_r;
    assign read          = read_r;
    assign write         = write_r;

endmodule
